// File: rtl/song_note_sequencer_pkg.sv
// song_note_sequencer_pkg: song ROM entry layout, marker codes and FSM state encodings.
//   entry_t packs [7:5] note, [4:1] beats, [0] gap flag.
package song_note_sequencer_pkg;
   localparam int BEATS_W = 4;
   localparam logic [2:0] NOTE_REST = 3'd0;
   localparam logic [BEATS_W-1:0] BEATS_END = '0;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LATCH = 3'd2;
   localparam logic [2:0] S_PLAY  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   typedef struct packed {
      logic [2:0]         note;
      logic [BEATS_W-1:0] beats;
      logic               gap;
   } entry_t;
endpackage

// File: rtl/song_note_sequencer_beat_timer.sv
// song_note_sequencer_beat_timer: counts LEN cycles per beat over a loaded number of beats.
//   clk, rst_n : clock, async active-low reset
//   load       : restart with cycle count 0 and beat count = beats
//   run        : advance one cycle
//   expired    : high during the final cycle of the final beat (while run)
module song_note_sequencer_beat_timer
   import song_note_sequencer_pkg::*;
#(
   parameter int LEN = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               run,
   input  logic [BEATS_W-1:0] beats,
   output logic               expired
);
   localparam int W = LEN > 1 ? $clog2(LEN) : 1;
   logic [W-1:0]       cnt;
   logic [BEATS_W-1:0] left;
   logic               wrap;
   assign wrap    = cnt == W'(LEN - 1);
   assign expired = run && wrap && left == BEATS_W'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt  <= '0;
         left <= '0;
      end else if (load) begin
         cnt  <= '0;
         left <= beats;
      end else if (run) begin
         cnt  <= wrap ? '0 : cnt + 1'b1;
         left <= wrap ? left - 1'b1 : left;
      end
endmodule

// File: rtl/song_note_sequencer.sv
// song_note_sequencer: steps a song ROM and drives note_number/en for the buzzer tone stage.
//   start/stop/loop_en : playback control (stop has priority)
//   rom_addr/rom_data  : synchronous song ROM, data valid one cycle after address
//   note_number/en     : registered note and tone enable
//   busy/done          : playback active, one-cycle natural end-of-song pulse
module song_note_sequencer
   import song_note_sequencer_pkg::*;
#(
   parameter int BEAT_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 2_500_000,
   parameter int SONG_LEN    = 32,
   parameter int ADDR_W      = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [2:0]        note_number,
   output logic              en,
   output logic              busy,
   output logic              done
);
   logic [2:0] state;
   logic       gap_flag;
   logic       play_exp, gap_exp, step, song_end;
   entry_t     ent;
   assign ent = rom_data;
   // step: current entry finished normally; song_end: marker seen or last entry finished
   assign step     = (state == S_PLAY && play_exp && !gap_flag) || (state == S_GAP && gap_exp);
   assign song_end = (state == S_LATCH && ent.beats == BEATS_END) ||
                     (step && rom_addr == ADDR_W'(SONG_LEN - 1));
   song_note_sequencer_beat_timer #(.LEN(BEAT_CYCLES)) u_play (
      .clk(clk), .rst_n(rst_n), .load(state == S_LATCH), .run(state == S_PLAY),
      .beats(ent.beats), .expired(play_exp)
   );
   song_note_sequencer_beat_timer #(.LEN(GAP_CYCLES)) u_gap (
      .clk(clk), .rst_n(rst_n), .load(state == S_PLAY && play_exp), .run(state == S_GAP),
      .beats(BEATS_W'(1)), .expired(gap_exp)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= S_IDLE;
         rom_addr    <= '0;
         note_number <= '0;
         en          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         gap_flag    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state       <= S_IDLE;
            rom_addr    <= '0;
            note_number <= '0;
            en          <= 1'b0;
            busy        <= 1'b0;
         end else if (song_end) begin
            if (loop_en) begin
               rom_addr <= '0;
               state    <= S_FETCH;
            end else begin
               state       <= S_IDLE;
               note_number <= '0;
               en          <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b1;
            end
         end else if (step) begin
            rom_addr <= rom_addr + 1'b1;
            state    <= S_FETCH;
         end else
            case (state)
               S_IDLE:
                  if (start) begin
                     rom_addr <= '0;
                     busy     <= 1'b1;
                     state    <= S_FETCH;
                  end
               S_FETCH: state <= S_LATCH;
               S_LATCH: begin
                  note_number <= ent.note;
                  en          <= ent.note != NOTE_REST;
                  gap_flag    <= ent.gap;
                  state       <= S_PLAY;
               end
               // only the gap case reaches here; the no-gap case is a step
               S_PLAY:
                  if (play_exp) begin
                     en    <= 1'b0;
                     state <= S_GAP;
                  end
               default: ;
            endcase
      end
endmodule

// File: tb/tb_song_note_sequencer.sv
// tb_song_note_sequencer: scoreboard bench; expected per-cycle output trace is built from the ROM table.
module tb_song_note_sequencer;
   localparam int BC = 4, GC = 2, SL = 4;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
   logic [1:0] rom_addr;
   logic [7:0] rom_data = '0;
   logic [2:0] note_number;
   logic       en, busy, done;
   logic [7:0] rom [SL];
   logic [8:0] q [$];
   int         n_checks = 0, n_fail = 0, last_rem = 0;

   song_note_sequencer #(.BEAT_CYCLES(BC), .GAP_CYCLES(GC), .SONG_LEN(SL), .ADDR_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .note_number(note_number),
      .en(en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [8:0] pk(input int a, input logic b, input logic d, input logic e,
                                     input logic [2:0] n);
      return {2'(a), b, d, e, n};
   endfunction

   // expected outputs {rom_addr,busy,done,en,note} one per cycle after the start edge
   task automatic build(input int loops);
      int a = 0, pass = 0, mark = 0, nb;
      logic [2:0] n = 3'd0;
      logic e = 1'b0, fin = 1'b0, eos;
      repeat (2) q.push_back(pk(0, 1, 0, e, n));
      while (!fin) begin
         nb  = int'(rom[a][4:1]);
         eos = 1'b0;
         if (nb == 0) eos = 1'b1;
         else begin
            n = rom[a][7:5];
            e = n != 3'd0;
            repeat (nb * BC) q.push_back(pk(a, 1, 0, e, n));
            if (rom[a][0]) begin
               e = 1'b0;
               repeat (GC) q.push_back(pk(a, 1, 0, e, n));
            end
            if (a == SL - 1) eos = 1'b1;
            else begin
               a++;
               repeat (2) q.push_back(pk(a, 1, 0, e, n));
            end
         end
         if (eos) begin
            if (pass < loops) begin
               pass++;
               mark = q.size();
               a = 0;
               repeat (2) q.push_back(pk(0, 1, 0, e, n));
            end else begin
               q.push_back(pk(a, 0, 1, 0, 0));
               repeat (3) q.push_back(pk(a, 0, 0, 0, 0));
               fin = 1'b1;
            end
         end
      end
      last_rem = q.size() - mark;
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) check("trace", {rom_addr, busy, done, en, note_number}, q.pop_front());
   end

   task automatic pulse_start(input int loops, input logic expect_run);
      @(negedge clk);
      start = 1'b1;
      if (expect_run) build(loops);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() > 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", q.size(), 0);
   endtask

   task automatic idle_checks(input string tag);
      repeat (4) begin
         @(negedge clk);
         check(tag, {rom_addr, busy, done, en, note_number}, 0);
      end
   endtask

   initial begin
      int t;
      rom = '{8'h00, 8'h00, 8'h00, 8'h00};
      repeat (2) @(negedge clk);
      check("reset_outputs", {rom_addr, busy, done, en, note_number}, 0);
      rst_n = 1'b1;
      // note 3 x2 beats; note 5 x1 beat with gap; end marker
      rom = '{8'h64, 8'hA3, 8'h00, 8'h00};
      pulse_start(0, 1'b1);
      drain();
      // rest of 3 beats between two notes
      rom = '{8'h42, 8'h06, 8'h82, 8'h00};
      pulse_start(0, 1'b1);
      drain();
      // four entries without marker, looping twice then ending
      rom = '{8'h22, 8'h45, 8'h02, 8'hE3};
      loop_en = 1'b1;
      pulse_start(2, 1'b1);
      t = 0;
      while (q.size() >= last_rem && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("loop_wait_timeout", t < 3000, 1);
      loop_en = 1'b0;
      drain();
      // start pulses while busy must not disturb the reference sequence
      rom = '{8'h64, 8'hA3, 8'h00, 8'h00};
      pulse_start(0, 1'b1);
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      // stop during PLAY
      pulse_start(0, 1'b0);
      repeat (5) @(negedge clk);
      check("pre_stop_note", {en, note_number}, {1'b1, 3'd3});
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_outputs", {rom_addr, busy, done, en, note_number}, 0);
      idle_checks("after_stop");
      // stop and start together in IDLE
      @(negedge clk);
      stop  = 1'b1;
      start = 1'b1;
      @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
      check("stop_start_outputs", {rom_addr, busy, done, en, note_number}, 0);
      idle_checks("stop_start_idle");
      // asynchronous reset in the middle of a note
      pulse_start(0, 1'b0);
      repeat (5) @(negedge clk);
      check("pre_reset_note", {busy, en, note_number}, {1'b1, 1'b1, 3'd3});
      #2 rst_n = 1'b0;
      #1 check("async_reset", {rom_addr, busy, done, en, note_number}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_checks("after_reset");
      pulse_start(0, 1'b1);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
